saida_bcd_display: RTL
======================

// Module: saida_bcd_display
// PURPOSE
//  Downstream consumer of the data-memory output register (the 32-bit "saida" value
//  written by OUT instructions). Converts the binary value to decimal with a sequential
//  shift-add-3 (double-dabble) engine and drives DIGITS seven-segment displays.
//  Holds the last converted value on the displays until a new one is loaded.
// PARAMETERS
//  WIDTH      32  width of the binary input value (unsigned)
//  DIGITS     10  BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1
//  SEG_ACT_LO 1   1: segment lit when bit=0 (DE-board style); 0: lit when bit=1
//  BLANK_LZ   1   1: blank leading zeros (digit 0 always shown); 0: show all digits
// PORTS
//  clock     in   1           system clock, all state on rising edge
//  resetn    in   1           asynchronous active-low reset
//  valor_in  in   WIDTH       binary value to display (connect to saida)
//  carrega   in   1           load strobe; valor_in sampled on the edge where carrega=1
//  ocupado   out  1           1 while a conversion is in progress
//  pronto    out  1           1-cycle pulse when displays take a new value
//  bcd_out   out  4*DIGITS    converted BCD, digit 0 (units) in bits [3:0]
//  seg_out   out  7*DIGITS    segments, digit i in [7i+6:7i], bit order gfedcba (bit 6=g)
// BEHAVIOUR
//  Reset (resetn=0, async): state=OCIOSO, ocupado=0, pronto=0, bcd_out=0, pending flag
//   cleared; seg_out shows "0" in digit 0 and all other digits blank if BLANK_LZ=1, else
//   "0" in every digit. Reset mid-conversion aborts it; displays return to reset value.
//  FSM states: OCIOSO, CONVERTE, FIM.
//   OCIOSO: carrega=1 -> latch valor_in into shift reg, clear BCD scratch, cnt=0,
//    go CONVERTE (ocupado=1 from next cycle).
//   CONVERTE: each cycle: add 3 to every scratch digit >=5, then shift {scratch,shreg}
//    left by 1; cnt++. After WIDTH iterations (cnt==WIDTH-1 on the edge) go FIM.
//   FIM: copy scratch to bcd_out, update seg_out, pronto=1 for this one cycle;
//    next state OCIOSO, or CONVERTE directly if a pending load exists.
//  Latency: carrega sampled at edge N -> bcd_out/seg_out update and pronto=1 after
//   edge N+WIDTH+1 (33 cycles for WIDTH=32). Outputs stable between updates.
//  Load while busy (CONVERTE or FIM): valor_in captured into a one-deep pending
//   register; a later load while pending overwrites it (last value wins). Pending is
//   started from FIM without passing through OCIOSO; pending flag clears when started.
//  carrega held high in OCIOSO: treated as repeated loads (one conversion each, back
//   to back via the pending path).
//  Segment encoding 0-9 standard; codes A-F never occur; blank = all segments off
//   (7'h7F when SEG_ACT_LO=1, 7'h00 otherwise).
//  Leading-zero blanking: digit i blank iff BLANK_LZ=1, i>0 and all digits >=i are 0.
//  Arithmetic: unsigned only; no sign handling; WIDTH+4*DIGITS internal shift width.
// TESTING
//  1 Reset release, no load -> ocupado=0, bcd_out=0, seg digit0=7'h40, digits1-9=7'h7F.
//  2 carrega pulse with valor_in=1234 -> pronto exactly 33 cycles later, bcd_out=
//    40'h0000001234, seg digits0-3 = 7'h19,7'h30,7'h24,7'h79, digits4-9 blank.
//  3 valor_in=32'hFFFFFFFF -> bcd_out=40'h4294967295, no digit blanked, ocupado low after.
//  4 load 7, then load 99 and 500 mid-conversion -> two pronto pulses only; first shows 7,
//    second shows 500 (99 dropped), second follows first with no idle cycle.
//  5 resetn low 10 cycles into conversion of 88 -> outputs return to reset value at once;
//    after release no pronto until a new carrega.
//  6 BLANK_LZ=0, SEG_ACT_LO=0, value 0 -> all ten digits = 7'h3F, bcd_out=0.

Source files
------------

// File: rtl/saida_bcd_display.sv
// ============================================================================
//  Module      : saida_bcd_display
//  Description : Sequential double-dabble binary-to-BCD converter that drives
//                DIGITS seven-segment displays from the data-memory OUT value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module saida_bcd_display #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DIGITS     = 10,
   parameter bit          SEG_ACT_LO = 1'b1,
   parameter bit          BLANK_LZ   = 1'b1
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [WIDTH-1:0]      valor_in,
   input  logic                  carrega,
   output logic                  ocupado,
   output logic                  pronto,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int unsigned      c_CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(WIDTH - 1);
   localparam logic [6:0]       c_BLANK    = SEG_ACT_LO ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONVERTE = 2'd1,
      FIM      = 2'd2
   } estado_t;

   estado_t               r_estado;
   logic [WIDTH-1:0]      r_shreg;
   logic [4*DIGITS-1:0]   r_scr;
   logic [c_CW-1:0]       r_cnt;
   logic                  r_pend;
   logic [WIDTH-1:0]      r_pend_val;
   logic [4*DIGITS-1:0]   w_adj;
   logic [7*DIGITS-1:0]   w_seg;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] lit;
      case (d)
         4'd0:    lit = 7'h3F;
         4'd1:    lit = 7'h06;
         4'd2:    lit = 7'h5B;
         4'd3:    lit = 7'h4F;
         4'd4:    lit = 7'h66;
         4'd5:    lit = 7'h6D;
         4'd6:    lit = 7'h7D;
         4'd7:    lit = 7'h07;
         4'd8:    lit = 7'h7F;
         4'd9:    lit = 7'h6F;
         default: lit = 7'h00;
      endcase
      seg_of = SEG_ACT_LO ? ~lit : lit;
   endfunction

   // Walk from the most significant digit so lz tracks "this and all higher digits are 0".
   function automatic logic [7*DIGITS-1:0] seg_vec(input logic [4*DIGITS-1:0] bcd);
      logic       lz;
      logic [3:0] d;
      seg_vec = '0;
      lz      = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d  = bcd[4*i +: 4];
         lz = lz & (d == 4'd0);
         if (BLANK_LZ && (i > 0) && lz)
            seg_vec[7*i +: 7] = c_BLANK;
         else
            seg_vec[7*i +: 7] = seg_of(d);
      end
   endfunction

   always_comb begin
      w_adj = r_scr;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (r_scr[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_seg = seg_vec(r_scr);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_estado   <= OCIOSO;
         r_shreg    <= '0;
         r_scr      <= '0;
         r_cnt      <= '0;
         r_pend     <= 1'b0;
         r_pend_val <= '0;
         ocupado    <= 1'b0;
         pronto     <= 1'b0;
         bcd_out    <= '0;
         seg_out    <= seg_vec('0);
      end else begin
         pronto <= 1'b0;
         case (r_estado)
            OCIOSO: begin
               if (carrega) begin
                  r_shreg  <= valor_in;
                  r_scr    <= '0;
                  r_cnt    <= '0;
                  ocupado  <= 1'b1;
                  r_estado <= CONVERTE;
               end
            end
            CONVERTE: begin
               {r_scr, r_shreg} <= {w_adj[4*DIGITS-2:0], r_shreg, 1'b0};
               r_cnt            <= r_cnt + c_CW'(1);
               if (r_cnt == c_CNT_LAST)
                  r_estado <= FIM;
               if (carrega) begin
                  r_pend     <= 1'b1;
                  r_pend_val <= valor_in;
               end
            end
            FIM: begin
               bcd_out <= r_scr;
               seg_out <= w_seg;
               pronto  <= 1'b1;
               // A load arriving on this very edge is the newest pending value.
               if (carrega || r_pend) begin
                  r_shreg  <= carrega ? valor_in : r_pend_val;
                  r_scr    <= '0;
                  r_cnt    <= '0;
                  r_pend   <= 1'b0;
                  r_estado <= CONVERTE;
               end else begin
                  ocupado  <= 1'b0;
                  r_estado <= OCIOSO;
               end
            end
            default: begin
               ocupado  <= 1'b0;
               r_estado <= OCIOSO;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
